// File: rtl/fifo_word_unpacker.sv
// Drains 192-bit words from the lane FIFO and streams them out as one lane per
// cycle, lane 0 first, tagging the last lane of the last word of each frame.
module fifo_word_unpacker #(
  parameter int LANE_WIDTH  = 32,
  parameter int LANES       = 6,
  parameter int FRAME_WORDS = 4,
  localparam int LANE_IDX_W  = $clog2(LANES),
  localparam int FRAME_CNT_W = $clog2(FRAME_WORDS) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [LANE_WIDTH*LANES-1:0] fifo_dout,
  input  logic                        fifo_out_valid,
  input  logic                        fifo_empty,
  output logic                        fifo_request,
  output logic [LANE_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [LANE_IDX_W-1:0]       m_lane,
  output logic                        m_last,
  output logic                        busy
);

  localparam logic [LANE_IDX_W-1:0]  LAST_LANE = LANE_IDX_W'(LANES - 1);
  localparam logic [FRAME_CNT_W-1:0] LAST_WORD = FRAME_CNT_W'(FRAME_WORDS - 1);

  logic [LANE_WIDTH*LANES-1:0] hold;
  logic                        hold_valid;
  logic [LANE_IDX_W-1:0]       lane;
  logic [FRAME_CNT_W-1:0]      word_cnt;
  logic                        last_lane;
  logic                        lane_fire;
  logic                        unused_status;

  // Stream handshake: a lane transfers on every rising edge where m_valid and
  // m_ready are both high; while m_valid && !m_ready, data/lane/last hold still.
  assign last_lane = (lane == LAST_LANE);
  assign lane_fire = hold_valid && m_ready;

  // Requesting on the final lane's accept lets the next word land on the same
  // edge, so a always-ready consumer sees no bubble between words.
  assign fifo_request = !rst && !flush && (!hold_valid || (m_ready && last_lane));

  assign m_data  = hold[lane*LANE_WIDTH +: LANE_WIDTH];
  assign m_valid = hold_valid;
  assign m_lane  = lane;
  assign m_last  = hold_valid && last_lane && (word_cnt == LAST_WORD);
  assign busy    = hold_valid;

  // The FIFO gates its own out_valid; the empty flag is observed only.
  assign unused_status = fifo_empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      lane       <= '0;
      word_cnt   <= '0;
    end else begin
      if (lane_fire) begin
        if (last_lane) begin
          word_cnt   <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
          hold_valid <= 1'b0;
        end else begin
          lane <= lane + 1'b1;
        end
      end
      // A same-edge reload overrides the clear above and keeps the block full.
      if (fifo_out_valid) begin
        hold       <= fifo_dout;
        hold_valid <= 1'b1;
        lane       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Bench for fifo_word_unpacker: queue-based FIFO model, lane-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_fifo_word_unpacker;

  localparam int LW = 32;
  localparam int NL = 6;
  localparam int FW = 4;
  localparam int WW = LW * NL;
  localparam logic [WW-1:0] GARBAGE = {6{32'hBAD0_BAD0}};

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [WW-1:0] fifo_dout;
  logic          fifo_out_valid;
  logic          fifo_empty;
  logic          fifo_request;
  logic [LW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [2:0]    m_lane;
  logic          m_last;
  logic          busy;

  fifo_word_unpacker #(.LANE_WIDTH(LW), .LANES(NL), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fifo_dout(fifo_dout), .fifo_out_valid(fifo_out_valid), .fifo_empty(fifo_empty),
    .fifo_request(fifo_request),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_lane(m_lane), .m_last(m_last), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout at %0t", name, $time);
  endtask

  // ---------------- FIFO model ----------------
  logic [WW-1:0] fifo_q[$];
  bit            pop_pending = 1'b0;

  assign fifo_out_valid = fifo_request && !fifo_empty;

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? GARBAGE : fifo_q[0];
  endtask

  always @(posedge clk) begin
    #1;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_pending = 1'b0;
    refresh();
  end

  // ---------------- reference model + scoreboard ----------------
  // Model view: a word is a list of lanes queued for delivery; frame position is
  // a single count of lanes delivered since the frame start.
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] fire_log[$];
  int            pulse_q[$];
  bit            held = 1'b0;
  int            pos = 0;
  int            fires = 0;
  int            valid_cycles = 0;
  int            req_held_cycles = 0;

  always @(negedge clk) begin
    int  exp_lane;
    bit  exp_req;
    exp_lane = pos % NL;
    exp_req  = !rst && !flush && (!held || (m_ready && exp_lane == NL - 1));
    check("fifo_request", 64'(fifo_request), 64'(exp_req));
    check("m_valid", 64'(m_valid), 64'(held));
    check("busy", 64'(busy), 64'(held));
    check("m_last", 64'(m_last), 64'(held && pos == NL * FW - 1));
    if (held) begin
      valid_cycles++;
      if (fifo_request) req_held_cycles++;
      check("m_lane", 64'(m_lane), 64'(exp_lane));
      if (exp_q.size() == 0) timeout("scoreboard_empty");
      else check("m_data", 64'(m_data), 64'(exp_q[0]));
    end
    pop_pending = fifo_out_valid;
    if (rst || flush) begin
      held = 1'b0;
      pos  = 0;
      exp_q.delete();
    end else begin
      if (held && m_ready) begin
        fires++;
        fire_log.push_back(m_data);
        if (m_last) pulse_q.push_back(fires);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (exp_lane == NL - 1) held = 1'b0;
        pos = (pos + 1) % (NL * FW);
      end
      if (fifo_out_valid) begin
        held = 1'b1;
        for (int i = 0; i < NL; i++) exp_q.push_back(fifo_dout[i*LW +: LW]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [WW-1:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int i = 0; i < NL; i++) w[i*LW +: LW] = $urandom();
    return w;
  endfunction

  function automatic logic [WW-1:0] pattern_word(input logic [LW-1:0] base);
    logic [WW-1:0] w;
    for (int i = 0; i < NL; i++) w[i*LW +: LW] = base + LW'(i);
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    m_ready = 1'b0;
    fifo_q.delete();
    refresh();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 800; i++) begin
      if (fifo_q.size() == 0 && !busy) return;
      tick();
    end
    timeout(name);
  endtask

  task automatic wait_fires(input int target, input string name);
    for (int i = 0; i < 400; i++) begin
      if (fires >= target) return;
      tick();
    end
    timeout(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_f, base_p, base_v, base_r, sz;
    logic [WW-1:0] w1;
    bit pat[10];

    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    refresh();
    tick(); tick(); tick();

    // Reset values and first request after release
    rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_lane", 64'(m_lane), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_release_req", 64'(fifo_request), 64'd1);

    // Preloaded FIFO, always-ready consumer, 8 words = 2 frames
    do_reset();
    m_ready = 1'b1;
    base_f = fires; base_p = pulse_q.size(); base_v = valid_cycles; base_r = req_held_cycles;
    push_word(pattern_word(32'hA));
    for (int k = 1; k < 8; k++) push_word(rand_word());
    wait_drain("stream_drain");
    check("stream_fires", 64'(fires - base_f), 64'd48);
    check("stream_valid_cycles", 64'(valid_cycles - base_v), 64'd48);
    check("stream_req_lane5", 64'(req_held_cycles - base_r), 64'd8);
    check("stream_last_pulses", 64'(pulse_q.size() - base_p), 64'd2);
    if (pulse_q.size() >= base_p + 2) begin
      check("stream_last_pos0", 64'(pulse_q[base_p] - base_f), 64'd24);
      check("stream_last_pos1", 64'(pulse_q[base_p+1] - base_f), 64'd48);
    end
    for (int i = 0; i < NL; i++)
      check("w0_lane_data", 64'(fire_log[base_f+i]), 64'(32'hA + i));

    // Consumer stall during a word
    do_reset();
    pat = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1};
    base_f = fires;
    push_word(pattern_word(32'h100));
    push_word(rand_word());
    tick();
    for (int i = 0; i < 10; i++) begin
      m_ready = pat[i];
      tick();
    end
    m_ready = 1'b1;
    wait_fires(base_f + NL, "stall_word");
    for (int i = 0; i < NL; i++)
      check("stall_lane_data", 64'(fire_log[base_f+i]), 64'(32'h100 + i));
    wait_drain("stall_drain");

    // FIFO runs dry after W0, W1 arrives 5 cycles later
    do_reset();
    m_ready = 1'b1;
    push_word(pattern_word(32'h200));
    wait_drain("empty_drain");
    for (int i = 0; i < 5; i++) tick();
    w1 = pattern_word(32'h300);
    push_word(w1);
    @(negedge clk);
    check("empty_req_high", 64'(fifo_request), 64'd1);
    check("empty_not_valid", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("empty_w1_valid", 64'(m_valid), 64'd1);
    check("empty_w1_lane", 64'(m_lane), 64'd0);
    check("empty_w1_data", 64'(m_data), 64'h300);
    tick();
    wait_drain("empty_w1_drain");

    // Flush at lane 3 of word 2
    do_reset();
    m_ready = 1'b1;
    base_f = fires;
    for (int k = 0; k < 4; k++) push_word(rand_word());
    tick();
    wait_fires(base_f + 2 * NL + 3, "flush_wait");
    flush = 1'b1;
    @(negedge clk);
    check("flush_req_low", 64'(fifo_request), 64'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_m_valid", 64'(m_valid), 64'd0);
    check("flush_m_lane", 64'(m_lane), 64'd0);
    tick();
    base_f = fires; base_p = pulse_q.size();
    for (int k = 0; k < 3; k++) push_word(rand_word());
    wait_drain("flush_drain");
    check("flush_last_pulses", 64'(pulse_q.size() - base_p), 64'd1);
    if (pulse_q.size() > base_p)
      check("flush_last_pos", 64'(pulse_q[base_p] - base_f), 64'd24);

    // Reset at lane 2 with consumer ready
    do_reset();
    m_ready = 1'b1;
    base_f = fires;
    for (int k = 0; k < 3; k++) push_word(rand_word());
    tick();
    wait_fires(base_f + 2, "rst_mid_wait");
    rst = 1'b1;
    sz = fifo_q.size();
    @(negedge clk);
    check("rstmid_req_low", 64'(fifo_request), 64'd0);
    tick();
    check("rstmid_m_valid", 64'(m_valid), 64'd0);
    check("rstmid_m_data", 64'(m_data), 64'd0);
    check("rstmid_m_lane", 64'(m_lane), 64'd0);
    check("rstmid_m_last", 64'(m_last), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    tick();
    check("rstmid_fifo_untouched", 64'(fifo_q.size()), 64'(sz));
    rst = 1'b0;
    wait_drain("rstmid_drain");

    // Randomized traffic with ready jitter and occasional flushes
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 99) == 0);
      if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1) push_word(rand_word());
      tick();
    end
    flush = 1'b0;
    m_ready = 1'b1;
    wait_drain("random_drain");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
